// File: rtl/frame_gen_pkg.sv
// Shared types for the frame_gen_mp test-pattern source: pattern/FSM enums and
// the colour-bar table (R,G,B on/off masks, bit 2 = R).
package frame_gen_pkg;

    typedef enum logic [1:0] {
        SOLID = 2'd0,
        BARS  = 2'd1,
        GRAD  = 2'd2,
        CHECK = 2'd3
    } mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [2:0] BAR_MASK [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                            3'b101, 3'b100, 3'b001, 3'b000};

    function automatic logic [2:0] bar_mask(input logic [2:0] idx);
        return BAR_MASK[idx];
    endfunction

endpackage

// File: rtl/frame_gen_mp_pattern.sv
// Combinational pixel colour for one pattern position: (xp, y, bar index, mode,
// solid colour) -> RGB. No state; the top registers the result.
module frame_gen_mp_pattern
    import frame_gen_pkg::*;
#(
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int BPC      = 4,
    parameter int CHK_LOG2 = 4
) (
    input  logic [XW-1:0]         xp,
    input  logic [YW-1:0]         y,
    input  logic [2:0]            bar,
    input  mode_t                 mode,
    input  logic [2:0][BPC-1:0]   solid_rgb,
    output logic [2:0][BPC-1:0]   rgb
);

    // Widened copies so BPC / CHK_LOG2 may exceed the counter widths safely.
    logic [31:0] xp_w;
    logic [31:0] y_w;
    logic [2:0]  mask;
    logic        unused_bits;

    assign xp_w        = 32'(xp);
    assign y_w         = 32'(y);
    assign mask        = bar_mask(bar);
    assign unused_bits = ^{xp_w, y_w};

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        rgb = '0;
        case (mode)
            SOLID: rgb = solid_rgb;
            BARS: begin
                for (int c = 0; c < 3; c++) rgb[c] = {BPC{mask[c]}};
            end
            GRAD: begin
                for (int c = 0; c < 3; c++) rgb[c] = xp_w[BPC-1:0];
            end
            CHECK: begin
                if (xp_w[CHK_LOG2] ^ y_w[CHK_LOG2]) rgb = '1;
            end
            default: rgb = '0;
        endcase
    end

endmodule

// File: rtl/frame_gen_mp.sv
// Multi-pattern AXI4-Stream video test-frame source (tuser = SOF, tlast = EOL).
// Define FRAME_GEN_SCROLL_EN to shift the pattern by SCROLL pixels every frame.
module frame_gen_mp
    import frame_gen_pkg::*;
#(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int BPC      = 4,
    parameter int CHK_LOG2 = 4,
    parameter int SCROLL   = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  sof,
    input  logic [1:0]            mode,
    input  logic [2:0][BPC-1:0]   solid_rgb,
    output logic                  pix_tvalid,
    input  logic                  pix_tready,
    output logic [2:0][BPC-1:0]   pix_tdata,
    output logic                  pix_tlast,
    output logic                  pix_tuser,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int XW    = $clog2(H_RES);
    localparam int YW    = $clog2(V_RES);
    localparam int BAR_W = H_RES / 8;

    localparam logic [XW-1:0] X_LAST  = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(V_RES - 1);
    localparam logic [XW-1:0] BW_LAST = XW'(BAR_W - 1);

    state_t state_q, state_d;

    // Coordinates of the pixel currently held in the output register.
    logic [XW-1:0] x_q, bw_q;
    logic [YW-1:0] y_q;
    logic [2:0]    bar_q;
    logic          sof_pend;
    mode_t         mode_q;
    logic [2:0][BPC-1:0] solid_q;

    logic hs, run, line_end, last_px, last_hs;
    logic start_idle, chain, frame_start, step;

    logic [XW-1:0] x_n, xp_n, bw_n, bw_init;
    logic [YW-1:0] y_n;
    logic [2:0]    bar_n, bar_init;
    mode_t         mode_sel;
    logic [2:0][BPC-1:0] solid_sel, rgb_n;

    assign hs          = pix_tvalid & pix_tready;
    assign run         = (state_q == RUN);
    assign busy        = run;
    assign line_end    = (x_q == X_LAST);
    assign last_px     = line_end && (y_q == Y_LAST);
    assign last_hs     = run && hs && last_px;
    assign start_idle  = !run && (sof || sof_pend);
    // A request seen during a frame chains the next one with no idle gap.
    assign chain       = last_hs && (sof || sof_pend);
    assign frame_start = start_idle || chain;
    assign step        = run && hs && !last_px;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_idle) state_d = RUN;
            RUN:     if (last_hs && !chain) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (frame_start) begin
            x_n   = '0;
            y_n   = '0;
            bw_n  = bw_init;
            bar_n = bar_init;
        end else begin
            x_n = line_end ? '0 : x_q + 1'b1;
            y_n = line_end ? y_q + 1'b1 : y_q;
            // Bar index advances every BAR_W pixels and wraps 7 -> 0 with the line.
            if (bw_q == BW_LAST) begin
                bw_n  = '0;
                bar_n = bar_q + 3'd1;
            end else begin
                bw_n  = bw_q + 1'b1;
                bar_n = bar_q;
            end
        end
    end

`ifdef FRAME_GEN_SCROLL_EN
    logic [XW-1:0] offset_q, xp_q;
    logic [XW:0]   offset_sum;

    assign offset_sum = {1'b0, offset_q} + (XW+1)'(SCROLL);
    assign xp_n = frame_start ? offset_q : ((xp_q == X_LAST) ? '0 : xp_q + 1'b1);

    // Locate the bar containing the frame's first pixel with constant compares.
    always_comb begin
        bar_init = '0;
        bw_init  = offset_q;
        for (int k = 1; k < 8; k++) begin
            if (offset_q >= XW'(k * BAR_W)) begin
                bar_init = 3'(k);
                bw_init  = offset_q - XW'(k * BAR_W);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            offset_q <= '0;
            xp_q     <= '0;
        end else begin
            if (frame_start)
                offset_q <= (offset_sum >= (XW+1)'(H_RES)) ? XW'(offset_sum - (XW+1)'(H_RES))
                                                           : XW'(offset_sum);
            if (frame_start || step) xp_q <= xp_n;
        end
    end
`else
    localparam int unused_scroll = SCROLL;

    assign xp_n     = x_n;
    assign bar_init = '0;
    assign bw_init  = '0;
`endif

    assign mode_sel  = frame_start ? mode_t'(mode) : mode_q;
    assign solid_sel = frame_start ? solid_rgb : solid_q;

    frame_gen_mp_pattern #(
        .XW       (XW),
        .YW       (YW),
        .BPC      (BPC),
        .CHK_LOG2 (CHK_LOG2)
    ) u_pattern (
        .xp        (xp_n),
        .y         (y_n),
        .bar       (bar_n),
        .mode      (mode_sel),
        .solid_rgb (solid_sel),
        .rgb       (rgb_n)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            bw_q       <= '0;
            bar_q      <= '0;
            sof_pend   <= 1'b0;
            mode_q     <= SOLID;
            solid_q    <= '0;
            pix_tvalid <= 1'b0;
            pix_tdata  <= '0;
            pix_tlast  <= 1'b0;
            pix_tuser  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_done <= last_hs;

            if (frame_start)     sof_pend <= 1'b0;
            else if (run && sof) sof_pend <= 1'b1;

            if (frame_start) begin
                mode_q  <= mode_t'(mode);
                solid_q <= solid_rgb;
            end

            if (frame_start || step) begin
                x_q        <= x_n;
                y_q        <= y_n;
                bw_q       <= bw_n;
                bar_q      <= bar_n;
                pix_tvalid <= 1'b1;
                pix_tdata  <= rgb_n;
                pix_tlast  <= (x_n == X_LAST);
                pix_tuser  <= (x_n == '0) && (y_n == '0);
            end else if (last_hs) begin
                x_q        <= '0;
                y_q        <= '0;
                pix_tvalid <= 1'b0;
                pix_tdata  <= '0;
                pix_tlast  <= 1'b0;
                pix_tuser  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frame_gen_mp.sv
// Scoreboard bench for frame_gen_mp: expected beats come from an arithmetic
// pattern model; a negedge monitor pops and compares every accepted beat.
module tb_frame_gen_mp;

    localparam int H_RES    = 16;
    localparam int V_RES    = 4;
    localparam int BPC      = 4;
    localparam int CHK_LOG2 = 1;
    localparam int SCROLL   = 3;
`ifdef FRAME_GEN_SCROLL_EN
    localparam bit SCROLL_ON = 1'b1;
`else
    localparam bit SCROLL_ON = 1'b0;
`endif

    logic                aclk = 1'b0;
    logic                aresetn = 1'b0;
    logic                sof = 1'b0;
    logic [1:0]          mode = 2'd0;
    logic [2:0][BPC-1:0] solid_rgb = '0;
    logic                pix_tvalid;
    logic                pix_tready = 1'b1;
    logic [2:0][BPC-1:0] pix_tdata;
    logic                pix_tlast;
    logic                pix_tuser;
    logic                busy;
    logic                frame_done;

    frame_gen_mp #(
        .H_RES    (H_RES),
        .V_RES    (V_RES),
        .BPC      (BPC),
        .CHK_LOG2 (CHK_LOG2),
        .SCROLL   (SCROLL)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .sof        (sof),
        .mode       (mode),
        .solid_rgb  (solid_rgb),
        .pix_tvalid (pix_tvalid),
        .pix_tready (pix_tready),
        .pix_tdata  (pix_tdata),
        .pix_tlast  (pix_tlast),
        .pix_tuser  (pix_tuser),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [11:0] data;
        logic        last;
        logic        user;
        logic        eof;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    beats_seen = 0;
    int    frames_since_reset = 0;
    bit    rdy_rand = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pattern computed directly from the colour rules.
    function automatic logic [11:0] ref_pixel(int m, logic [11:0] solid, int off, int x, int y);
        int xp;
        int v;
        xp = (x + off) % H_RES;
        case (m)
            0: return solid;
            1: begin
                case (xp / (H_RES / 8))
                    0: return 12'hFFF;
                    1: return 12'hFF0;
                    2: return 12'h0FF;
                    3: return 12'h0F0;
                    4: return 12'hF0F;
                    5: return 12'hF00;
                    6: return 12'h00F;
                    default: return 12'h000;
                endcase
            end
            2: begin
                v = xp % (1 << BPC);
                return {4'(v), 4'(v), 4'(v)};
            end
            default: return ((((xp >> CHK_LOG2) ^ (y >> CHK_LOG2)) & 1) != 0) ? 12'hFFF : 12'h000;
        endcase
    endfunction

    task automatic push_frame(input int m, input logic [11:0] solid);
        int    off;
        beat_t b;
        off = SCROLL_ON ? (frames_since_reset * SCROLL) % H_RES : 0;
        frames_since_reset++;
        for (int y = 0; y < V_RES; y++) begin
            for (int x = 0; x < H_RES; x++) begin
                b.data = ref_pixel(m, solid, off, x, y);
                b.last = (x == H_RES - 1);
                b.user = (x == 0) && (y == 0);
                b.eof  = (x == H_RES - 1) && (y == V_RES - 1);
                sb.push_back(b);
            end
        end
    endtask

    task automatic issue_sof(input bit from_idle);
        @(posedge aclk);
        #1 sof = 1'b1;
        @(posedge aclk);
        #1 sof = 1'b0;
        if (from_idle) begin
            check("start_tvalid", pix_tvalid, 1);
            check("start_tuser", pix_tuser, 1);
            check("start_busy", busy, 1);
        end
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 4000; i++) begin
            if (beats_seen >= n) return;
            @(negedge aclk);
        end
        checks++;
        errors++;
        $display("FAIL wait_beats: got %0d beats, expected %0d", beats_seen, n);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4000; i++) begin
            @(negedge aclk);
            if (sb.size() == 0 && !busy && !pix_tvalid) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: %0d beats still expected, busy=%0b", sb.size(), busy);
        sb.delete();
    endtask

    task automatic run_frame(input int m);
        mode = 2'(m);
        solid_rgb = 12'($urandom);
        push_frame(m, solid_rgb);
        issue_sof(1'b1);
        wait_idle();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tvalid"}, pix_tvalid, 0);
        check({tag, "_tdata"}, pix_tdata, 0);
        check({tag, "_tlast"}, pix_tlast, 0);
        check({tag, "_tuser"}, pix_tuser, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    task automatic hard_reset();
        @(posedge aclk);
        #1 aresetn = 1'b0;
        sb.delete();
        frames_since_reset = 0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge aclk);
            #1 pix_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pops, stall stability, frame continuity, frame_done timing.
    bit          prev_stall = 0;
    bit          prev_eof = 0;
    bit          prev_cont = 0;
    logic [11:0] held_data;
    logic        held_last, held_user;

    always @(negedge aclk) begin
        beat_t e;
        if (!aresetn) begin
            prev_stall = 0;
            prev_eof   = 0;
            prev_cont  = 0;
        end else begin
            check("frame_done", frame_done, prev_eof);
            if (prev_cont) check("tvalid_in_frame", pix_tvalid, 1);
            if (prev_stall) begin
                check("stall_tvalid", pix_tvalid, 1);
                check("stall_tdata", pix_tdata, held_data);
                check("stall_tlast", pix_tlast, held_last);
                check("stall_tuser", pix_tuser, held_user);
            end
            prev_stall = pix_tvalid && !pix_tready;
            held_data  = pix_tdata;
            held_last  = pix_tlast;
            held_user  = pix_tuser;
            prev_eof   = 0;
            prev_cont  = 0;
            if (pix_tvalid && pix_tready) begin
                beats_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", pix_tdata);
                end else begin
                    e = sb.pop_front();
                    check("beat_tdata", pix_tdata, e.data);
                    check("beat_tlast", pix_tlast, e.last);
                    check("beat_tuser", pix_tuser, e.user);
                    prev_eof  = e.eof;
                    prev_cont = (sb.size() != 0);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int base;

        repeat (3) @(negedge aclk);
        check_outputs_zero("reset");
        @(posedge aclk);
        #1 aresetn = 1'b1;

        // Every pattern with an always-ready sink.
        run_frame(1);
        run_frame(0);
        run_frame(2);
        run_frame(3);

        // Random backpressure.
        rdy_rand = 1'b1;
        run_frame(1);
        run_frame(3);
        run_frame(0);
        rdy_rand = 1'b0;

        // Two requests during a frame collapse into one chained frame.
        mode = 2'd1;
        base = beats_seen;
        push_frame(1, solid_rgb);
        issue_sof(1'b1);
        wait_beats(base + 10);
        push_frame(1, solid_rgb);
        issue_sof(1'b0);
        wait_beats(base + 20);
        issue_sof(1'b0);
        wait_idle();
        repeat (5) @(negedge aclk);
        check("b2b_no_extra_busy", busy, 0);
        check("b2b_no_extra_tvalid", pix_tvalid, 0);

        // Mode change mid-frame only affects the following frame.
        mode = 2'd3;
        base = beats_seen;
        push_frame(3, solid_rgb);
        issue_sof(1'b1);
        wait_beats(base + 5);
        mode = 2'd2;
        push_frame(2, solid_rgb);
        issue_sof(1'b0);
        wait_idle();

        // Random mid-frame input changes under backpressure.
        rdy_rand = 1'b1;
        for (int f = 0; f < 4; f++) begin
            int m;
            m = $urandom_range(0, 3);
            mode = 2'(m);
            solid_rgb = 12'($urandom);
            base = beats_seen;
            push_frame(m, solid_rgb);
            issue_sof(1'b1);
            wait_beats(base + $urandom_range(1, 60));
            mode = 2'($urandom);
            solid_rgb = 12'($urandom);
            wait_idle();
        end
        rdy_rand = 1'b0;

        // Reset mid-frame aborts it; the next request starts a fresh frame.
        mode = 2'd1;
        base = beats_seen;
        push_frame(1, solid_rgb);
        issue_sof(1'b1);
        wait_beats(base + 30);
        aresetn = 1'b0;
        sb.delete();
        frames_since_reset = 0;
        @(posedge aclk);
        #1 check_outputs_zero("abort");
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        run_frame(3);

        // Gradient/bars over consecutive frames (scrolls when the feature is built in).
        hard_reset();
        for (int f = 0; f < 6; f++) run_frame(2);
        run_frame(1);

        repeat (5) @(negedge aclk);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
